// File: rtl/fifo_drain_packer_if.sv
// fifo_drain_packer_if
//   Bundles the FIFO read port and the packed valid/ready output stream
//   of fifo_drain_packer.
//   Optional macro FIFO_DRAIN_PACKER_FLUSH_EN adds flush, out_last, out_count.
// Signals
//   empty      FIFO empty flag
//   rdata      FIFO head word (show-ahead)
//   rreq       pop request to the FIFO
//   out_valid  packed word available
//   out_data   packed word, first-popped word in the low lane
//   out_ready  consumer accepts out_data
//   flush      (FLUSH_EN) emit a partially filled word
//   out_last   (FLUSH_EN) word ended by a flush
//   out_count  (FLUSH_EN) number of filled lanes in out_data
// Modports
//   master  packer side
//   slave   FIFO / consumer side
interface fifo_drain_packer_if #(
  parameter int BYTE_SIZE = 8,
  parameter int PACK      = 4
);
  localparam int CNT_W = $clog2(PACK + 1);

  logic                        empty;
  logic [BYTE_SIZE-1:0]        rdata;
  logic                        rreq;
  logic                        out_valid;
  logic [BYTE_SIZE*PACK-1:0]   out_data;
  logic                        out_ready;
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
  logic                        flush;
  logic                        out_last;
  logic [CNT_W-1:0]            out_count;
`endif

  modport master (
    input  empty, rdata, out_ready,
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
    input  flush,
    output out_last, out_count,
`endif
    output rreq, out_valid, out_data
  );

  modport slave (
    output empty, rdata, out_ready,
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
    output flush,
    input  out_last, out_count,
`endif
    input  rreq, out_valid, out_data
  );
endinterface

// File: rtl/fifo_drain_packer.sv
// fifo_drain_packer
//   Pops BYTE_SIZE-bit words from a show-ahead FIFO whenever it is not empty,
//   packs PACK consecutive words into one wide word and presents it on a
//   valid/ready stream. The first-popped word lands in the lowest lane.
//   Optional macro FIFO_DRAIN_PACKER_FLUSH_EN adds a flush input that emits
//   a partially filled word, plus out_last / out_count sideband outputs.
// Ports
//   clock   single clock, all state on posedge
//   reset   asynchronous, active-high
//   io      fifo_drain_packer_if.master (FIFO read port + output stream)
//
// state | meaning
// ------+--------------------------------------------------------------
// FILL  | accumulating words, lane index idx counts 0..PACK-1
// HOLD  | packed word presented with out_valid=1, no pops until accepted
module fifo_drain_packer #(
  parameter int BYTE_SIZE = 8,
  parameter int PACK      = 4
) (
  input logic                clock,
  input logic                reset,
  fifo_drain_packer_if.master io
);
  localparam int IDX_W = (PACK > 2) ? $clog2(PACK) : 1;
  localparam int CNT_W = $clog2(PACK + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PACK - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(PACK);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic                      valid_q;
  logic [BYTE_SIZE*PACK-1:0] data_q;
  logic                      pop;

  // reset term makes rreq drop the instant reset asserts, not at the next edge
  assign pop       = (state == FILL) && !io.empty && !reset;
  assign io.rreq   = pop;
  assign io.out_valid = valid_q;
  assign io.out_data  = data_q;

`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
  logic             last_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] fill_n;

  // lanes that will be filled after this edge, including a same-cycle pop
  assign fill_n       = CNT_W'(idx) + CNT_W'(pop);
  assign io.out_last  = last_q;
  assign io.out_count = count_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= FILL;
      idx     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
      last_q  <= 1'b0;
      count_q <= '0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (pop) begin
            data_q[int'(idx)*BYTE_SIZE +: BYTE_SIZE] <= io.rdata;
          end
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
          if (io.flush && (fill_n != '0)) begin
            // unused lanes are already 0: lanes are cleared on every handshake
            state   <= HOLD;
            idx     <= '0;
            valid_q <= 1'b1;
            count_q <= fill_n;
            last_q  <= 1'b1;
          end else
`endif
          if (pop) begin
            if (idx == LAST_IDX) begin
              state   <= HOLD;
              idx     <= '0;
              valid_q <= 1'b1;
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
              count_q <= FULL_CNT;
              last_q  <= 1'b0;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (io.out_ready) begin
            state   <= FILL;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
            count_q <= '0;
            last_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state   <= FILL;
          idx     <= '0;
          valid_q <= 1'b0;
          data_q  <= '0;
        end
      endcase
    end
  end

`ifndef FIFO_DRAIN_PACKER_FLUSH_EN
  // keep the full-word count constant referenced in the default build
  logic unused_full_cnt;
  assign unused_full_cnt = ^FULL_CNT;
`endif
endmodule

// File: tb/tb_fifo_drain_packer.sv
module tb_fifo_drain_packer;
  localparam int BYTE_SIZE = 8;
  localparam int PACK      = 4;

  logic clock;
  logic reset;

  fifo_drain_packer_if #(.BYTE_SIZE(BYTE_SIZE), .PACK(PACK)) ifc ();

  fifo_drain_packer #(.BYTE_SIZE(BYTE_SIZE), .PACK(PACK)) dut (
    .clock (clock),
    .reset (reset),
    .io    (ifc.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [7:0]  fifo_q[$];
  logic [31:0] exp_q[$];
  logic        stall = 1'b0;
  logic        pop_seen;

  task automatic drive_fifo();
    ifc.empty = (fifo_q.size() == 0) || stall;
    ifc.rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // FIFO model: head advances on a posedge where rreq was high
  always @(posedge clock) begin
    pop_seen = ifc.rreq;
    #1;
    if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive_fifo();
  end

  task automatic push_words(input logic [7:0] first, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(first + 8'(i));
      w[(i % PACK)*8 +: 8] = first + 8'(i);
      if ((i % PACK) == PACK - 1) begin
        exp_q.push_back(w);
        w = '0;
      end
    end
    drive_fifo();
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (ifc.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [31:0] next_exp();
    return (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    ifc.out_ready = 1'b0;
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
    ifc.flush = 1'b0;
`endif
    drive_fifo();
    repeat (2) @(negedge clock);
    total++;
    if (ifc.out_valid !== 1'b0 || ifc.rreq !== 1'b0 || ifc.out_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: valid=%b rreq=%b data=%h, want 0 0 00000000",
               ifc.out_valid, ifc.rreq, ifc.out_data);
    end
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
    total++;
    if (ifc.out_last !== 1'b0 || ifc.out_count !== 3'd0) begin
      bad++;
      $display("FAIL reset_side: last=%b count=%0d, want 0 0", ifc.out_last, ifc.out_count);
    end
`endif
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int  rreq_cycles;
    bit  ok;
    logic [31:0] e;
    ifc.out_ready = 1'b1;
    push_words(8'h01, 4);
    rreq_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ifc.out_valid) begin
        ok = 1'b1;
        break;
      end
      if (ifc.rreq) rreq_cycles++;
      @(negedge clock);
    end
    e = next_exp();
    total++;
    if (!ok || ifc.out_data !== e) begin
      bad++;
      $display("FAIL basic_data: valid=%b data=%h, want 1 %h", ok, ifc.out_data, e);
    end
    total++;
    if (rreq_cycles !== 4) begin
      bad++;
      $display("FAIL basic_rreq_cycles: got %0d, want 4", rreq_cycles);
    end
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
    total++;
    if (ifc.out_count !== 3'd4 || ifc.out_last !== 1'b0) begin
      bad++;
      $display("FAIL basic_side: count=%0d last=%b, want 4 0", ifc.out_count, ifc.out_last);
    end
`endif
    @(negedge clock);
    total++;
    if (ifc.out_valid !== 1'b0 || ifc.out_data !== 32'h0) begin
      bad++;
      $display("FAIL basic_one_cycle: valid=%b data=%h, want 0 00000000",
               ifc.out_valid, ifc.out_data);
    end
  endtask

  task automatic test_backpressure();
    bit  ok;
    int  hold_err;
    logic [31:0] e;
    ifc.out_ready = 1'b0;
    push_words(8'h11, 8);
    wait_valid(20, ok);
    e = next_exp();
    total++;
    if (!ok || ifc.out_data !== e) begin
      bad++;
      $display("FAIL bp_first: valid=%b data=%h, want 1 %h", ok, ifc.out_data, e);
    end
    hold_err = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (ifc.out_valid !== 1'b1 || ifc.out_data !== e || ifc.rreq !== 1'b0 || ifc.empty !== 1'b0)
        hold_err++;
    end
    total++;
    if (hold_err != 0) begin
      bad++;
      $display("FAIL bp_hold: %0d bad hold cycles, want 0", hold_err);
    end
    ifc.out_ready = 1'b1;
    wait_valid(20, ok);
    e = next_exp();
    total++;
    if (!ok || ifc.out_data !== e) begin
      bad++;
      $display("FAIL bp_second: valid=%b data=%h, want 1 %h", ok, ifc.out_data, e);
    end
    @(negedge clock);
  endtask

  task automatic test_empty_gaps();
    int  viol;
    int  stalled;
    bit  ok;
    logic [31:0] e;
    ifc.out_ready = 1'b1;
    push_words(8'h21, 4);
    viol = 0;
    stalled = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      stall = ~stall;
      drive_fifo();
      #1;
      if (ifc.out_valid) begin
        ok = 1'b1;
        break;
      end
      if (ifc.empty && ifc.rreq) viol++;
      if (stall && fifo_q.size() != 0) stalled++;
      @(negedge clock);
    end
    stall = 1'b0;
    drive_fifo();
    e = next_exp();
    total++;
    if (!ok || ifc.out_data !== e) begin
      bad++;
      $display("FAIL gaps_data: valid=%b data=%h, want 1 %h", ok, ifc.out_data, e);
    end
    total++;
    if (viol != 0 || stalled == 0) begin
      bad++;
      $display("FAIL gaps_no_pop_on_empty: viol=%0d stalled=%0d, want 0 and >0", viol, stalled);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_fill();
    bit  ok;
    logic [31:0] e;
    ifc.out_ready = 1'b1;
    push_words(8'h31, 6);
    exp_q.delete();
    exp_q.push_back(32'h36353433);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    total++;
    if (ifc.rreq !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.out_data !== 32'h0) begin
      bad++;
      $display("FAIL midreset_outputs: rreq=%b valid=%b data=%h, want 0 0 00000000",
               ifc.rreq, ifc.out_valid, ifc.out_data);
    end
    repeat (2) @(negedge clock);
    total++;
    if (fifo_q.size() !== 4) begin
      bad++;
      $display("FAIL midreset_fifo_left: %0d words, want 4", fifo_q.size());
    end
    reset = 1'b0;
    wait_valid(20, ok);
    e = next_exp();
    total++;
    if (!ok || ifc.out_data !== e) begin
      bad++;
      $display("FAIL midreset_data: valid=%b data=%h, want 1 %h", ok, ifc.out_data, e);
    end
    @(negedge clock);
  endtask

`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
  task automatic test_flush_partial();
    bit  ok;
    int  seen;
    ifc.out_ready = 1'b0;
    fifo_q.push_back(8'h0A);
    fifo_q.push_back(8'h0B);
    drive_fifo();
    exp_q.push_back(32'h00000B0A);
    repeat (3) @(negedge clock);
    ifc.flush = 1'b1;
    wait_valid(5, ok);
    ifc.flush = 1'b0;
    total++;
    if (!ok || ifc.out_data !== next_exp() || ifc.out_count !== 3'd2 || ifc.out_last !== 1'b1) begin
      bad++;
      $display("FAIL flush_partial: valid=%b data=%h count=%0d last=%b, want 1 00000b0a 2 1",
               ok, ifc.out_data, ifc.out_count, ifc.out_last);
    end
    ifc.out_ready = 1'b1;
    @(negedge clock);
    ifc.flush = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (ifc.out_valid) seen++;
    end
    ifc.flush = 1'b0;
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL flush_empty_ignored: %0d valid cycles, want 0", seen);
    end
  endtask

  task automatic test_flush_full();
    bit ok;
    ifc.out_ready = 1'b1;
    push_words(8'h41, 4);
    repeat (3) @(negedge clock);
    ifc.flush = 1'b1;
    @(posedge clock);
    #2;
    ifc.flush = 1'b0;
    wait_valid(5, ok);
    total++;
    if (!ok || ifc.out_data !== next_exp() || ifc.out_count !== 3'd4 || ifc.out_last !== 1'b1) begin
      bad++;
      $display("FAIL flush_full: valid=%b data=%h count=%0d last=%b, want 1 44434241 4 1",
               ok, ifc.out_data, ifc.out_count, ifc.out_last);
    end
    @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_gaps();
    test_reset_mid_fill();
`ifdef FIFO_DRAIN_PACKER_FLUSH_EN
    test_flush_partial();
    test_flush_full();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
